// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor front end: instruction width,
// opcode encodings, instruction-fetch FSM states and the default halt word.
package proc_pkg;

  localparam int unsigned INST_W = 8;

  // Opcode field inst[7:6]
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] OP_ALU   = 2'b11;

  // End-of-program marker used when halt detection is compiled in
  localparam logic [INST_W-1:0] HALT_WORD_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_SW_WAIT,
    ST_SW_ISSUE,
    ST_DONE
  } fetch_state_e;

  // One-hot opcode decode helper for downstream core logic
  function automatic logic [3:0] op_onehot(input logic [INST_W-1:0] inst);
    logic [3:0] oh;
    oh = 4'b0000;
    case (inst[7:6])
      OP_LOAD:  oh = 4'b0001;
      OP_STORE: oh = 4'b0010;
      OP_MOVE:  oh = 4'b0100;
      OP_ALU:   oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for a raw button.
// Ports: clk, clr_n (async active-low reset), btn (asynchronous level),
//        pulse (one-cycle high on each synchronized rising edge).
module btn_edge_sync (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Metastability chain, edge history and registered pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse   <= sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction sequencer feeding the 4-bit core over a valid/ready handshake.
// Sources: ROM programs (auto-fetch from external synchronous ROM) or the
// switch word, one instruction per debounced load-button press.
// Optional macro HALT_DETECT_EN: a fetched/loaded word equal to HALT_WORD
// ends the program without being issued.
// Ports:
//   clk, clr_n             clock, async active-low reset
//   start, inst_sel,       start pulse; source and ROM program latched on start
//   rom_sel
//   sw_data, sw_load       switch instruction word and raw load button
//   rom_addr, rom_data     {program, pc} address out; word back one cycle later
//   inst_out, inst_valid,  registered instruction handshake to the core
//   core_ready
//   pc, busy, done         next index to issue, running, end of program
module inst_fetch_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 5,
  parameter logic [INST_W-1:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                start,
  input  logic                inst_sel,
  input  logic [1:0]          rom_sel,
  input  logic [INST_W-1:0]   sw_data,
  input  logic                sw_load,
  output logic [ADDR_W+1:0]   rom_addr,
  input  logic [INST_W-1:0]   rom_data,
  output logic [INST_W-1:0]   inst_out,
  output logic                inst_valid,
  input  logic                core_ready,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done
);

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  fetch_state_e        state_q, state_d;
  logic                rom_mode_q, rom_mode_d;
  logic [1:0]          rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [INST_W-1:0]   inst_d;
  logic                valid_d;
  logic                busy_d;
  logic                done_d;
  logic                load_pulse;

  function automatic logic is_halt(input logic [INST_W-1:0] w);
    return HALT_EN && (w == HALT_WORD);
  endfunction

  btn_edge_sync u_load_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (sw_load),
    .pulse (load_pulse)
  );

  // ROM address is the latched program select over the current pc
  assign rom_addr = {rom_sel_q, pc};

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    rom_mode_d = rom_mode_q;
    rom_sel_d  = rom_sel_q;
    pc_d       = pc;
    inst_d     = inst_out;
    valid_d    = inst_valid;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A coincident load edge is consumed here and never issued
        if (start) begin
          rom_mode_d = inst_sel;
          rom_sel_d  = rom_sel;
          pc_d       = '0;
          valid_d    = 1'b0;
          state_d    = inst_sel ? ST_FETCH : ST_SW_WAIT;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (is_halt(rom_data)) begin
          state_d = ST_DONE;
        end else begin
          inst_d  = rom_data;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_SW_WAIT: begin
        if (load_pulse) begin
          if (is_halt(sw_data)) begin
            state_d = ST_DONE;
          end else begin
            inst_d  = sw_data;
            valid_d = 1'b1;
            state_d = ST_SW_ISSUE;
          end
        end
      end
      ST_ISSUE, ST_SW_ISSUE: begin
        // Load edges arriving here are dropped; pc saturates at the last word
        if (core_ready) begin
          valid_d = 1'b0;
          if (pc == PC_LAST) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = ADDR_W'(pc + 1'b1);
            state_d = rom_mode_q ? ST_FETCH : ST_SW_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_DONE});
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      rom_mode_q <= 1'b0;
      rom_sel_q  <= 2'b00;
      pc         <= '0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_mode_q <= rom_mode_d;
      rom_sel_q  <= rom_sel_d;
      pc         <= pc_d;
      inst_out   <= inst_d;
      inst_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl (ADDR_W=2, four 4-word programs).
module tb_inst_fetch_ctrl;
  import proc_pkg::*;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr_n = 1'b1;
  logic              start = 1'b0;
  logic              inst_sel = 1'b0;
  logic [1:0]        rom_sel = 2'b00;
  logic [INST_W-1:0] sw_data = '0;
  logic              sw_load = 1'b0;
  logic [AW+1:0]     rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic              core_ready = 1'b0;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;

  logic [INST_W-1:0] rom [4*DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]    acc_w[$];
  int            acc_c[$];
  logic [AW+1:0] addr_log[$];
  logic [7:0]    exp_w[$];
  int            exp_pc;

  typedef struct {
    logic [1:0] sel;
    int         mode;   // 0 ready always, 1 random ready, 2 five-cycle stall on word 1
    int         n_words;
    int         end_pc;
  } vec_t;
  vec_t vecs[5];

  inst_fetch_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .inst_sel   (inst_sel),
    .rom_sel    (rom_sel),
    .sw_data    (sw_data),
    .sw_load    (sw_load),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .core_ready (core_ready),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock: log acceptance, advance, check that unaccepted words held
  task automatic step();
    bit         acc;
    logic       pv_valid;
    logic [7:0] pv_out;
    acc      = inst_valid && core_ready;
    pv_valid = inst_valid;
    pv_out   = inst_out;
    if (acc) begin
      acc_w.push_back(inst_out);
      acc_c.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pv_valid && !acc) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_data", 32'(inst_out), 32'(pv_out));
    end
    if (busy && (addr_log.size() == 0 || addr_log[$] != rom_addr))
      addr_log.push_back(rom_addr);
  endtask

  // Reference: program words until end of ROM page or halt word
  function automatic void build_model(input logic [1:0] sel);
    exp_w.delete();
    exp_pc = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (HALT_EN && rom[int'(sel) * DEPTH + i] == HALT_WORD_DEFAULT) begin
        exp_pc = i;
        break;
      end
      exp_w.push_back(rom[int'(sel) * DEPTH + i]);
    end
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_inst"}, 32'(inst_out), 32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_rom(input logic [1:0] sel, input int mode, input int n_exp, input int pc_exp);
    bit bad_sel;
    bit bp_chk;
    int stall;
    int vcnt;
    int done_cyc;
    int nb;
    build_model(sel);
    acc_w.delete();
    acc_c.delete();
    addr_log.delete();
    bad_sel = 0; bp_chk = 0; stall = 0; vcnt = 0; done_cyc = -1;

    start = 1'b1; inst_sel = 1'b1; rom_sel = sel; core_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_pc", 32'(pc), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check("start_busy", 32'(busy), 32'd1);

    for (int k = 0; k < 300 && !done; k++) begin
      rom_sel  = 2'($urandom);
      inst_sel = 1'($urandom);
      start    = (k % 7 == 3);
      case (mode)
        0: core_ready = 1'b1;
        1: core_ready = 1'($urandom_range(0, 1));
        default: begin
          if (inst_valid && acc_w.size() == 1 && stall < 5) begin
            core_ready = 1'b0;
            stall++;
          end else begin
            core_ready = 1'b1;
          end
        end
      endcase
      if (busy && rom_addr[AW+1:AW] != sel) bad_sel = 1;
      if (inst_valid) vcnt++;
      nb = acc_w.size();
      step();
      if (done && done_cyc < 0) done_cyc = cyc;
      if (mode == 2 && stall == 5 && !bp_chk) begin
        bp_chk = 1;
        check("bp_inst", 32'(inst_out), 32'h11);
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_pc", 32'(pc), 32'd1);
      end
      if (mode == 2 && nb == 1 && acc_w.size() == 2)
        check("bp_pc_adv", 32'(pc), 32'd2);
    end
    start = 1'b0;

    check("run_done", 32'(done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_valid", 32'(inst_valid), 32'd0);
    check("run_pc", 32'(pc), 32'(pc_exp));
    check("run_count", 32'(acc_w.size()), 32'(n_exp));
    check("sel_stable", 32'(bad_sel), 32'd0);
    for (int i = 0; i < acc_w.size() && i < exp_w.size(); i++)
      check("run_word", 32'(acc_w[i]), 32'(exp_w[i]));
    check("addr_count", 32'(addr_log.size()), 32'(exp_pc + 1));
    for (int i = 0; i < addr_log.size() && i <= exp_pc; i++)
      check("addr_seq", 32'(addr_log[i]), 32'(int'(sel) * DEPTH + i));
    if (mode == 0) begin
      check("valid_cycles", 32'(vcnt), 32'(exp_w.size()));
      for (int i = 1; i < acc_c.size(); i++)
        check("issue_spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd3);
      if (acc_c.size() > 0)
        check("done_latency", 32'(done_cyc - acc_c[acc_c.size()-1]),
              (exp_w.size() == DEPTH) ? 32'd1 : 32'd3);
    end
  endtask

  task automatic press(input logic [7:0] d);
    sw_data = d;
    sw_load = 1'b1;
    repeat (5) step();
    sw_load = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    logic [7:0] sw_exp[$];
    logic [7:0] d;

    for (int i = 0; i < DEPTH; i++) begin
      rom[0*DEPTH + i] = 8'(8'h10 + i);
      rom[1*DEPTH + i] = 8'(8'h20 + i);
      rom[2*DEPTH + i] = 8'(8'hA0 + i);
      rom[3*DEPTH + i] = 8'(8'h30 + i);
    end
    rom[1*DEPTH + 2] = 8'hFF;

    vecs[0] = '{sel: 2'd2, mode: 0, n_words: 4, end_pc: 3};
    vecs[1] = '{sel: 2'd0, mode: 2, n_words: 4, end_pc: 3};
    vecs[2] = '{sel: 2'd1, mode: 0, n_words: HALT_EN ? 2 : 4, end_pc: HALT_EN ? 2 : 3};
    vecs[3] = '{sel: 2'd3, mode: 1, n_words: 4, end_pc: 3};
    vecs[4] = '{sel: 2'd0, mode: 1, n_words: 4, end_pc: 3};

    // Power-on reset
    #1 clr_n = 1'b0;
    #2 check_outputs_zero("reset");
    @(negedge clk);
    clr_n = 1'b1;
    repeat (2) step();
    check("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[v]) run_rom(vecs[v].sel, vecs[v].mode, vecs[v].n_words, vecs[v].end_pc);

    // Randomized ROM runs against the reference model
    for (int r = 0; r < 6; r++) begin
      logic [1:0] s;
      s = 2'($urandom);
      build_model(s);
      run_rom(s, 1, exp_w.size(), exp_pc);
    end

    // Reset while an instruction is waiting for the core
    start = 1'b1; inst_sel = 1'b1; rom_sel = 2'd3; core_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && !inst_valid; k++) step();
    check("mid_valid_seen", 32'(inst_valid), 32'd1);
    #2 clr_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    @(negedge clk);
    clr_n = 1'b1;
    core_ready = 1'b1;
    repeat (4) step();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_valid", 32'(inst_valid), 32'd0);

    // Switch mode: one issue per press, presses during a pending issue dropped
    acc_w.delete();
    sw_exp.delete();
    inst_sel = 1'b0; start = 1'b1; core_ready = 1'b0;
    step();
    start = 1'b0;
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_novalid", 32'(inst_valid), 32'd0);
    press(8'h08);
    sw_exp.push_back(8'h08);
    check("sw_first", 32'(inst_out), 32'h08);
    check("sw_first_valid", 32'(inst_valid), 32'd1);
    press(8'h55);
    check("sw_drop_hold", 32'(inst_out), 32'h08);
    core_ready = 1'b1;
    repeat (6) step();
    check("sw_one_issue", 32'(acc_w.size()), 32'd1);
    check("sw_pc", 32'(pc), 32'd1);
    check("sw_valid_low", 32'(inst_valid), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 254));
      sw_exp.push_back(d);
      press(d);
    end
    check("sw_done", 32'(done), 32'd1);
    check("sw_end_pc", 32'(pc), 32'(DEPTH - 1));
    check("sw_count", 32'(acc_w.size()), 32'(DEPTH));
    for (int i = 0; i < acc_w.size() && i < sw_exp.size(); i++)
      check("sw_word", 32'(acc_w[i]), 32'(sw_exp[i]));
    press(8'h42);
    check("sw_after_done", 32'(acc_w.size()), 32'(DEPTH));
    check("sw_still_done", 32'(done), 32'd1);

    // Start and a load edge in the same cycle: the edge is discarded
    acc_w.delete();
    inst_sel = 1'b0; sw_data = 8'h66; sw_load = 1'b1;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("simul_count", 32'(acc_w.size()), 32'd0);
    check("simul_valid", 32'(inst_valid), 32'd0);
    check("simul_busy", 32'(busy), 32'd1);
    sw_load = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
